msi_irq_arbiter: RTL and testbench



---
 rtl/msi_irq_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_msi_irq_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/msi_irq_arbiter.sv
// msi_irq_arbiter -- shares the PCIe core's single MSI request/grant handshake
// between N_SRC level-sensitive interrupt sources (axi_clk_pcie domain; inputs
// must already be synchronous to clk).
//
// Ports:
//   clk           clock (axi_clk_pcie)
//   rst           synchronous, active-high reset
//   irq_i         level interrupt per source
//   msi_enabled   MSI enabled by host; low drops any request and all pending
//   msi_grant     core accepted the current request
//   msi_request   MSI request to the core, held until granted
//   msi_vector_o  zero-extended index of the source being served
//   pending_o     per-source pending flags (debug)
//   msi_count_o   granted MSIs since reset, wraps
//
// Optional build macro MSI_ARB_HOLDOFF_EN: stretches the post-grant HOLD state
// to HOLDOFF_CYCLES cycles. Undefined: HOLD is a single cycle.

// Per-source edge detector and pending flag.
module msi_irq_src (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic en,
  input  logic clr,
  output logic pending
);
  logic irq_q, irq_p, rise;

  // irq_q samples the level; rise compares it with the previous sample, so an
  // edge sampled at clock k becomes pending at k+1.
  assign rise = irq_q & ~irq_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= 1'b0;
      irq_p   <= 1'b0;
      pending <= 1'b0;
    end else begin
      irq_q <= irq;
      irq_p <= irq_q;
      if (!en)       pending <= 1'b0;
      else if (rise) pending <= 1'b1;  // a new edge beats the service clear
      else if (clr)  pending <= 1'b0;
    end
  end
endmodule

module msi_irq_arbiter #(
  parameter int N_SRC          = 4,
  parameter int VEC_W          = 5,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             msi_enabled,
  input  logic             msi_grant,
  output logic             msi_request,
  output logic [VEC_W-1:0] msi_vector_o,
  output logic [N_SRC-1:0] pending_o,
  output logic [15:0]      msi_count_o
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      last, last_nxt;
  logic               req_nxt;
  logic [VEC_W-1:0]   vec_nxt;
  logic [15:0]        cnt_nxt;
  logic [N_SRC-1:0]   pending, clr_vec;
  logic               found;
  logic [IW-1:0]      sel, idx;

`ifdef MSI_ARB_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  logic [HO_W-1:0] ho_cnt, ho_nxt;
`else
  logic holdoff_unused;
  assign holdoff_unused = (HOLDOFF_CYCLES != 0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      msi_irq_src u_src (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq_i[gi]),
        .en      (msi_enabled),
        .clr     (clr_vec[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  assign pending_o = pending;

  // Round-robin: first pending index scanning last+1, last+2, ... mod N_SRC.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx = IW'((int'(last) + off) % N_SRC);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = msi_request;
    vec_nxt   = msi_vector_o;
    last_nxt  = last;
    cnt_nxt   = msi_count_o;
    clr_vec   = '0;
`ifdef MSI_ARB_HOLDOFF_EN
    ho_nxt    = ho_cnt;
`endif
    if (!msi_enabled) begin
      // Ungranted request is dropped uncounted; pending flags clear in the cells.
      state_nxt = IDLE;
      req_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          vec_nxt      = VEC_W'(sel);
          clr_vec[sel] = 1'b1;
          req_nxt      = 1'b1;
          state_nxt    = REQ;
        end
        REQ: if (msi_grant) begin
          req_nxt   = 1'b0;
          last_nxt  = IW'(msi_vector_o);
          cnt_nxt   = msi_count_o + 16'd1;
          state_nxt = HOLD;
`ifdef MSI_ARB_HOLDOFF_EN
          ho_nxt    = HO_W'(HOLDOFF_CYCLES - 1);
`endif
        end
        HOLD: begin
`ifdef MSI_ARB_HOLDOFF_EN
          if (ho_cnt == '0) state_nxt = IDLE;
          else              ho_nxt    = ho_cnt - 1'b1;
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= IW'(N_SRC - 1);
      msi_request  <= 1'b0;
      msi_vector_o <= '0;
      msi_count_o  <= '0;
`ifdef MSI_ARB_HOLDOFF_EN
      ho_cnt       <= '0;
`endif
    end else begin
      state        <= state_nxt;
      last         <= last_nxt;
      msi_request  <= req_nxt;
      msi_vector_o <= vec_nxt;
      msi_count_o  <= cnt_nxt;
`ifdef MSI_ARB_HOLDOFF_EN
      ho_cnt       <= ho_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_msi_irq_arbiter.sv
module tb_msi_irq_arbiter;
  localparam int N = 4;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_i;
  logic          msi_enabled, msi_grant;
  logic          msi_request;
  logic [VW-1:0] msi_vector_o;
  logic [N-1:0]  pending_o;
  logic [15:0]   msi_count_o;
  int total = 0;
  int bad = 0;

  msi_irq_arbiter #(.N_SRC(N), .VEC_W(VW), .HOLDOFF_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .msi_enabled(msi_enabled),
    .msi_grant(msi_grant), .msi_request(msi_request), .msi_vector_o(msi_vector_o),
    .pending_o(pending_o), .msi_count_o(msi_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic grant_once();
    msi_grant = 1'b1; tick(1); msi_grant = 1'b0;
  endtask

  // Returns ticks until msi_request is seen, or -1 if the bound expires.
  task automatic wait_req(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (msi_request === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_i = '0; msi_grant = 1'b0; msi_enabled = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; irq_i = 4'b0001; msi_grant = 1'b0; msi_enabled = 1'b1;
    tick(3);
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL rst_req got=%0d want=0", msi_request); end
    total++; if (msi_vector_o !== 5'd0) begin bad++; $display("FAIL rst_vec got=%0d want=0", msi_vector_o); end
    total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL rst_pend got=%b want=0000", pending_o); end
    total++; if (msi_count_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", msi_count_o); end
    // irq_i already high at release counts as an edge
    rst = 1'b0;
    wait_req(n);
    total++; if (n !== 3) begin bad++; $display("FAIL rst_edge_lat got=%0d want=3", n); end
    total++; if (msi_vector_o !== 5'd0) begin bad++; $display("FAIL rst_edge_vec got=%0d want=0", msi_vector_o); end
    irq_i = '0;
    grant_once();
  endtask

  task automatic test_single();
    do_reset(); tick(1);
    irq_i = 4'b0001; tick(1); irq_i = '0;
    total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL s_pend0 got=%b want=0000", pending_o); end
    tick(1);
    total++; if (pending_o !== 4'b0001) begin bad++; $display("FAIL s_pend1 got=%b want=0001", pending_o); end
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL s_req_early got=%0d want=0", msi_request); end
    tick(1);
    total++; if (msi_request !== 1'b1) begin bad++; $display("FAIL s_req got=%0d want=1", msi_request); end
    total++; if (msi_vector_o !== 5'd0) begin bad++; $display("FAIL s_vec got=%0d want=0", msi_vector_o); end
    total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL s_pend_clr got=%b want=0000", pending_o); end
    tick(2);
    total++; if (msi_request !== 1'b1) begin bad++; $display("FAIL s_req_hold got=%0d want=1", msi_request); end
    grant_once();
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL s_req_drop got=%0d want=0", msi_request); end
    total++; if (msi_count_o !== 16'd1) begin bad++; $display("FAIL s_cnt got=%0d want=1", msi_count_o); end
    tick(3);
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL s_idle got=%0d want=0", msi_request); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    irq_i = 4'b0101; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd0 || n < 0) begin bad++; $display("FAIL rr_first got=%0d want=0", msi_vector_o); end
    total++; if (pending_o !== 4'b0100) begin bad++; $display("FAIL rr_pend got=%b want=0100", pending_o); end
    grant_once();
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL rr_gap1 got=%0d want=0", msi_request); end
    tick(1);
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL rr_gap2 got=%0d want=0", msi_request); end
    tick(1);
    total++; if (msi_request !== 1'b1 || msi_vector_o !== 5'd2) begin bad++; $display("FAIL rr_second got=%0d/%0d want=1/2", msi_request, msi_vector_o); end
    grant_once(); tick(1);
    // serve source 0 alone so the pointer sits at 0
    irq_i = 4'b0001; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd0 || n < 0) begin bad++; $display("FAIL rr_solo got=%0d want=0", msi_vector_o); end
    grant_once(); tick(1);
    irq_i = 4'b0011; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd1 || n < 0) begin bad++; $display("FAIL rr_rot1 got=%0d want=1", msi_vector_o); end
    grant_once(); tick(2);
    total++; if (msi_request !== 1'b1 || msi_vector_o !== 5'd0) begin bad++; $display("FAIL rr_rot0 got=%0d/%0d want=1/0", msi_request, msi_vector_o); end
    grant_once(); tick(2);
    total++; if (msi_count_o !== 16'd5) begin bad++; $display("FAIL rr_cnt got=%0d want=5", msi_count_o); end
  endtask

  task automatic test_coalesce();
    int n;
    do_reset();
    irq_i = 4'b0010; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd1 || n < 0) begin bad++; $display("FAIL co_vec got=%0d want=1", msi_vector_o); end
    repeat (3) begin irq_i = 4'b0010; tick(1); irq_i = '0; tick(1); end
    tick(2);
    total++; if (msi_request !== 1'b1 || pending_o !== 4'b0010) begin bad++; $display("FAIL co_pend got=%0d/%b want=1/0010", msi_request, pending_o); end
    grant_once(); tick(2);
    total++; if (msi_request !== 1'b1 || msi_vector_o !== 5'd1) begin bad++; $display("FAIL co_again got=%0d/%0d want=1/1", msi_request, msi_vector_o); end
    grant_once(); tick(6);
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL co_done got=%0d want=0", msi_request); end
    total++; if (msi_count_o !== 16'd2) begin bad++; $display("FAIL co_cnt got=%0d want=2", msi_count_o); end
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    irq_i = 4'b1001; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd0 || pending_o !== 4'b1000 || n < 0) begin bad++; $display("FAIL ab_setup got=%0d/%b want=0/1000", msi_vector_o, pending_o); end
    msi_enabled = 1'b0; tick(1);
    total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL ab_req got=%0d want=0", msi_request); end
    total++; if (pending_o !== 4'b0000) begin bad++; $display("FAIL ab_pend got=%b want=0000", pending_o); end
    total++; if (msi_count_o !== 16'd0) begin bad++; $display("FAIL ab_cnt got=%0d want=0", msi_count_o); end
    // level rising while disabled is absorbed by the edge detector
    irq_i = 4'b0100; tick(3);
    msi_enabled = 1'b1; tick(4);
    total++; if (msi_request !== 1'b0 || pending_o !== 4'b0000) begin bad++; $display("FAIL ab_reen got=%0d/%b want=0/0000", msi_request, pending_o); end
    irq_i = '0; tick(6);
    total++; if (msi_request !== 1'b0 || msi_count_o !== 16'd0) begin bad++; $display("FAIL ab_quiet got=%0d/%0d want=0/0", msi_request, msi_count_o); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    msi_grant = 1'b1;
    irq_i = 4'b1111; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (n !== 2) begin bad++; $display("FAIL bb_lat got=%0d want=2", n); end
    for (int v = 0; v < 4; v++) begin
      total++; if (msi_request !== 1'b1 || msi_vector_o !== 5'(v)) begin bad++; $display("FAIL bb_vec%0d got=%0d/%0d want=1/%0d", v, msi_request, msi_vector_o, v); end
      tick(1);
      total++; if (msi_request !== 1'b0 || msi_count_o !== 16'(v + 1)) begin bad++; $display("FAIL bb_cnt%0d got=%0d/%0d want=0/%0d", v, msi_request, msi_count_o, v + 1); end
      if (v < 3) tick(2);
    end
    tick(5);
    total++; if (msi_request !== 1'b0 || msi_count_o !== 16'd4) begin bad++; $display("FAIL bb_stray got=%0d/%0d want=0/4", msi_request, msi_count_o); end
    msi_grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    irq_i = 4'b0010; tick(1); irq_i = '0;
    wait_req(n); grant_once(); tick(1);
    irq_i = 4'b1001; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd3 || n < 0) begin bad++; $display("FAIL rm_vec3 got=%0d want=3", msi_vector_o); end
    rst = 1'b1; tick(1);
    total++; if (msi_request !== 1'b0 || msi_vector_o !== 5'd0 || pending_o !== 4'b0000 || msi_count_o !== 16'd0) begin bad++; $display("FAIL rm_clear got=%0d/%0d/%b/%0d want=0/0/0000/0", msi_request, msi_vector_o, pending_o, msi_count_o); end
    rst = 1'b0;
    irq_i = 4'b1001; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd0 || n < 0) begin bad++; $display("FAIL rm_ptr got=%0d want=0", msi_vector_o); end
    grant_once(); tick(2);
  endtask

`ifdef MSI_ARB_HOLDOFF_EN
  task automatic test_holdoff();
    int n;
    do_reset();
    irq_i = 4'b0011; tick(1); irq_i = '0;
    wait_req(n);
    total++; if (msi_vector_o !== 5'd0 || n < 0) begin bad++; $display("FAIL ho_first got=%0d want=0", msi_vector_o); end
    grant_once();
    for (int i = 1; i <= 8; i++) begin
      total++; if (msi_request !== 1'b0) begin bad++; $display("FAIL ho_gap%0d got=%0d want=0", i, msi_request); end
      tick(1);
    end
    tick(1);
    total++; if (msi_request !== 1'b1 || msi_vector_o !== 5'd1) begin bad++; $display("FAIL ho_second got=%0d/%0d want=1/1", msi_request, msi_vector_o); end
    grant_once();
  endtask
`endif

  initial begin
    rst = 1'b1; irq_i = '0; msi_enabled = 1'b1; msi_grant = 1'b0;
    test_reset();
`ifdef MSI_ARB_HOLDOFF_EN
    test_holdoff();
`else
    test_single();
    test_round_robin();
    test_coalesce();
    test_back_to_back();
`endif
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
